// File: rtl/cr_huf_comp_is_arb.sv
// Block-granular arbiter that shares one insertion-sort engine between two symbol-count producers.
// Optional macro CR_HUF_COMP_IS_ARB_STRICT_PRIO_EN: requester 0 always wins ties instead of round-robin.
module cr_huf_comp_is_arb #(
  parameter int DAT_WIDTH       = 10,
  parameter int CNT_WIDTH       = 3,
  parameter int SEQID_WIDTH     = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [3:0]               rq0_vld,
  input  logic [4*DAT_WIDTH-1:0]   rq0_sym,
  input  logic [4*CNT_WIDTH-1:0]   rq0_cnt,
  input  logic [SEQID_WIDTH-1:0]   rq0_seq_id,
  input  logic                     rq0_eob,
  output logic                     rq0_rd,

  input  logic [3:0]               rq1_vld,
  input  logic [4*DAT_WIDTH-1:0]   rq1_sym,
  input  logic [4*CNT_WIDTH-1:0]   rq1_cnt,
  input  logic [SEQID_WIDTH-1:0]   rq1_seq_id,
  input  logic                     rq1_eob,
  output logic                     rq1_rd,

  output logic [3:0]               sc_is_vld,
  output logic [4*DAT_WIDTH-1:0]   sc_is_sym,
  output logic [4*CNT_WIDTH-1:0]   sc_is_cnt,
  output logic [SEQID_WIDTH-1:0]   sc_is_seq_id,
  output logic                     sc_is_eob,
  input  logic                     is_sc_rd,

  input  logic                     ht_done,
  output logic                     ht_owner,
  output logic                     ht_owner_vld,
  output logic                     done_err,
  output logic                     busy
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t                     state;
  logic                       last_gnt;
  logic [OUT_W-1:0]           outstanding;
  logic [MAX_OUTSTANDING-1:0] tag_q;

  logic                       act0;
  logic                       act1;
  logic                       room;
  logic                       xfer;
  logic                       eob_xfer;
  logic                       pop;
  logic                       gnt_sel;
  logic                       cur_owner;
  logic [OUT_W-1:0]           wr_idx;
  logic [MAX_OUTSTANDING-1:0] tag_shift;
  logic [MAX_OUTSTANDING-1:0] tag_next;

  assign act0      = (|rq0_vld) | rq0_eob;
  assign act1      = (|rq1_vld) | rq1_eob;
  assign room      = outstanding < MAX_CNT;
  assign xfer      = ((|sc_is_vld) | sc_is_eob) & is_sc_rd;
  assign eob_xfer  = xfer & sc_is_eob;
  assign pop       = ht_done & (outstanding != '0);
  assign cur_owner = (state == GNT1);

`ifdef CR_HUF_COMP_IS_ARB_STRICT_PRIO_EN
  assign gnt_sel = ~act0;
`else
  assign gnt_sel = (act0 & act1) ? ~last_gnt : act1;
`endif

  // Combinational pass-through of the granted requester; nothing reaches the engine while idle.
  always_comb begin
    sc_is_vld    = '0;
    sc_is_sym    = '0;
    sc_is_cnt    = '0;
    sc_is_seq_id = '0;
    sc_is_eob    = 1'b0;
    rq0_rd       = 1'b0;
    rq1_rd       = 1'b0;
    case (state)
      GNT0: begin
        sc_is_vld    = rq0_vld;
        sc_is_sym    = rq0_sym;
        sc_is_cnt    = rq0_cnt;
        sc_is_seq_id = rq0_seq_id;
        sc_is_eob    = rq0_eob;
        rq0_rd       = is_sc_rd;
      end
      GNT1: begin
        sc_is_vld    = rq1_vld;
        sc_is_sym    = rq1_sym;
        sc_is_cnt    = rq1_cnt;
        sc_is_seq_id = rq1_seq_id;
        sc_is_eob    = rq1_eob;
        rq1_rd       = is_sc_rd;
      end
      default: ;
    endcase
  end

  // Owner FIFO kept as a shift register with the head at bit 0; a pop and push together land the new entry one slot lower.
  always_comb begin
    tag_shift = pop ? (tag_q >> 1) : tag_q;
    wr_idx    = pop ? (outstanding - 1'b1) : outstanding;
    tag_next  = tag_shift;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (eob_xfer && (wr_idx == OUT_W'(i))) begin
        tag_next[i] = cur_owner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      outstanding <= '0;
      tag_q       <= '0;
    end else begin
      tag_q <= tag_next;
      case ({eob_xfer, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      case (state)
        IDLE: begin
          if (room && (act0 || act1)) begin
            state <= gnt_sel ? GNT1 : GNT0;
          end
        end
        GNT0: begin
          if (eob_xfer) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
          end
        end
        GNT1: begin
          if (eob_xfer) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign ht_owner_vld = (outstanding != '0);
  assign ht_owner     = (outstanding != '0) & tag_q[0];
  assign done_err     = ht_done & (outstanding == '0);

endmodule

// File: tb/tb_cr_huf_comp_is_arb.sv
// Scoreboard bench for cr_huf_comp_is_arb: random blocks from both producers, block-order and owner-tag model.
module tb_cr_huf_comp_is_arb;

  localparam int DW      = 10;
  localparam int CW      = 3;
  localparam int SW      = 8;
  localparam int MAX_OUT = 2;

  typedef struct packed {
    logic [3:0]      vld;
    logic [4*DW-1:0] sym;
    logic [4*CW-1:0] cnt;
    logic [SW-1:0]   seq;
    logic            eob;
    logic            owner;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      rq0_vld, rq1_vld;
  logic [4*DW-1:0] rq0_sym, rq1_sym;
  logic [4*CW-1:0] rq0_cnt, rq1_cnt;
  logic [SW-1:0]   rq0_seq_id, rq1_seq_id;
  logic            rq0_eob, rq1_eob;
  logic            rq0_rd, rq1_rd;
  logic [3:0]      sc_is_vld;
  logic [4*DW-1:0] sc_is_sym;
  logic [4*CW-1:0] sc_is_cnt;
  logic [SW-1:0]   sc_is_seq_id;
  logic            sc_is_eob;
  logic            is_sc_rd;
  logic            ht_done;
  logic            ht_owner, ht_owner_vld, done_err, busy;

  beat_t    prod_q0[$];
  beat_t    prod_q1[$];
  beat_t    exp_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  logic [SW-1:0] seq_ctr = '0;

  cr_huf_comp_is_arb #(
    .DAT_WIDTH(DW), .CNT_WIDTH(CW), .SEQID_WIDTH(SW), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .rq0_vld(rq0_vld), .rq0_sym(rq0_sym), .rq0_cnt(rq0_cnt), .rq0_seq_id(rq0_seq_id),
    .rq0_eob(rq0_eob), .rq0_rd(rq0_rd),
    .rq1_vld(rq1_vld), .rq1_sym(rq1_sym), .rq1_cnt(rq1_cnt), .rq1_seq_id(rq1_seq_id),
    .rq1_eob(rq1_eob), .rq1_rd(rq1_rd),
    .sc_is_vld(sc_is_vld), .sc_is_sym(sc_is_sym), .sc_is_cnt(sc_is_cnt),
    .sc_is_seq_id(sc_is_seq_id), .sc_is_eob(sc_is_eob), .is_sc_rd(is_sc_rd),
    .ht_done(ht_done), .ht_owner(ht_owner), .ht_owner_vld(ht_owner_vld),
    .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [127:0] allOutputs();
    return 128'({sc_is_vld, sc_is_sym, sc_is_cnt, sc_is_seq_id, sc_is_eob,
                 rq0_rd, rq1_rd, ht_owner, ht_owner_vld, done_err, busy});
  endfunction

  // Blocks are generated in the order the arbiter must serve them when both producers stay loaded.
  task automatic applyStimulus(input int n0, input int n1, input int min_beats);
    int    r0 = n0;
    int    r1 = n1;
    logic  last = 1'b1;
    logic  pick;
    int    nb;
    beat_t b;
    logic [63:0] rnd;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) begin
`ifdef CR_HUF_COMP_IS_ARB_STRICT_PRIO_EN
        pick = 1'b0;
`else
        pick = ~last;
`endif
      end else begin
        pick = (r0 == 0);
      end
      last = pick;
      if (pick) r1--; else r0--;
      nb = int'($urandom_range(min_beats, 4));
      for (int i = 0; i < nb; i++) begin
        rnd     = {$urandom(), $urandom()};
        b.sym   = rnd[4*DW-1:0];
        b.cnt   = rnd[63 -: 4*CW];
        b.vld   = 4'($urandom_range(1, 15));
        b.eob   = (i == nb - 1);
        if (b.eob && ($urandom_range(0, 3) == 0)) b.vld = 4'h0;
        b.seq   = seq_ctr;
        b.owner = pick;
        if (pick) prod_q1.push_back(b); else prod_q0.push_back(b);
        exp_q.push_back(b);
      end
      seq_ctr++;
    end
  endtask

  task automatic driveHeads();
    beat_t h0, h1;
    h0 = '0;
    h1 = '0;
    if (prod_q0.size() != 0) h0 = prod_q0[0];
    if (prod_q1.size() != 0) h1 = prod_q1[0];
    rq0_vld = h0.vld; rq0_sym = h0.sym; rq0_cnt = h0.cnt; rq0_seq_id = h0.seq; rq0_eob = h0.eob;
    rq1_vld = h1.vld; rq1_sym = h1.sym; rq1_cnt = h1.cnt; rq1_seq_id = h1.seq; rq1_eob = h1.eob;
  endtask

  // done_mode: 0 = no ht_done, 1 = random pulses, 2 = pulse every cycle.
  task automatic stepCycle(input bit rnd_rd, input int done_mode);
    bit take0, take1;
    @(negedge clk);
    take0 = rq0_rd && (prod_q0.size() != 0);
    take1 = rq1_rd && (prod_q1.size() != 0);
    @(posedge clk);
    #1;
    if (take0) prod_q0.delete(0);
    if (take1) prod_q1.delete(0);
    driveHeads();
    is_sc_rd = rnd_rd ? ($urandom_range(0, 3) != 0) : 1'b1;
    case (done_mode)
      1:       ht_done = ($urandom_range(0, 9) == 0);
      2:       ht_done = 1'b1;
      default: ht_done = 1'b0;
    endcase
  endtask

  // Monitor: owner queue holds completed blocks awaiting ht_done, head first.
  initial begin : monitor
    beat_t e;
    logic  oq[$];
    bit    lat_pend = 0;
    bit    xfer, push_owner, act_any;
    logic  push_val;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        oq.delete();
        lat_pend = 0;
      end else begin
        push_owner = 0;
        push_val   = 1'b0;
        if (lat_pend) checkOutput("grant_latency", 128'(busy), 128'(1'b1));
        if (!busy)
          checkOutput("idle_outputs",
                      128'({sc_is_vld, sc_is_sym, sc_is_cnt, sc_is_seq_id, sc_is_eob, rq1_rd, rq0_rd}), '0);
        else
          checkOutput("rd_follow", 128'({rq1_rd | rq0_rd, rq1_rd & rq0_rd}), 128'({is_sc_rd, 1'b0}));
        if (oq.size() == MAX_OUT) checkOutput("limit_idle", 128'(busy), '0);
        checkOutput("ht_owner", 128'({ht_owner_vld, ht_owner}),
                    128'({oq.size() != 0, (oq.size() != 0) ? oq[0] : 1'b0}));
        checkOutput("done_err", 128'(done_err), 128'(ht_done && (oq.size() == 0)));
        xfer = ((|sc_is_vld) || sc_is_eob) && is_sc_rd;
        if (xfer) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 128'({sc_is_seq_id, sc_is_eob}), '0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat", 128'({sc_is_vld, sc_is_sym, sc_is_cnt, sc_is_seq_id, sc_is_eob}),
                        128'({e.vld, e.sym, e.cnt, e.seq, e.eob}));
            checkOutput("beat_owner", 128'({rq1_rd, rq0_rd}), 128'(e.owner ? 2'b10 : 2'b01));
            push_owner = e.eob;
            push_val   = e.owner;
          end
        end
        act_any  = (|rq0_vld) || rq0_eob || (|rq1_vld) || rq1_eob;
        lat_pend = !busy && act_any && (oq.size() < MAX_OUT);
        if (ht_done && oq.size() != 0) void'(oq.pop_front());
        if (push_owner) oq.push_back(push_val);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cyc;
    rst = 1'b1;
    is_sc_rd = 1'b0;
    ht_done = 1'b0;
    driveHeads();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", allOutputs(), '0);

    applyStimulus(5, 4, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    driveHeads();
    is_sc_rd = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      stepCycle(1, 1);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL traffic_timeout: %0d beats still expected, required 0", exp_q.size());
    end

    repeat (MAX_OUT + 3) stepCycle(1, 2);
    stepCycle(1, 0);

    applyStimulus(1, 0, 3);
    stepCycle(0, 0);
    stepCycle(0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    prod_q0.delete();
    prod_q1.delete();
    driveHeads();
    @(negedge clk);
    checkOutput("reset_midblock", allOutputs(), '0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_huf_comp_is_arb.md
Name: cr_huf_comp_is_arb

Overview:
- Block-granular arbiter sharing one insertion-sort engine (symbol counter + frequency sorter) between two symbol-count producers, requester 0 and requester 1.
- Sits between the two symbol-count producers and the engine's sc_* input side.
- Grants whole blocks (first beat through EOB beat), limits the number of blocks in flight inside the engine, and tags each completed engine result with the requester that owns it.

Parameters:
DAT_WIDTH, 10, symbol width per lane
CNT_WIDTH, 3, repeat count width per lane
SEQID_WIDTH, 8, sequence-id width
MAX_OUTSTANDING, 2, max blocks accepted by the engine whose result is not yet done (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rq_vld[r]  in  4  lane valids, requester r (r=0,1; one port set per requester)
rq_sym[r]  in  4*DAT_WIDTH  lane symbols, lane0 in LSBs
rq_cnt[r]  in  4*CNT_WIDTH  lane counts
rq_seq_id[r]  in  SEQID_WIDTH  block sequence id
rq_eob[r]  in  1  last beat of block
rq_rd[r]  out  1  beat accepted from requester r
sc_is_vld  out  4  engine lane valids
sc_is_sym  out  4*DAT_WIDTH  engine symbols
sc_is_cnt  out  4*CNT_WIDTH  engine counts
sc_is_seq_id  out  SEQID_WIDTH  engine seq id
sc_is_eob  out  1  engine end of block
is_sc_rd  in  1  engine ready
ht_done  in  1  one-cycle pulse: engine result for oldest outstanding block completed
ht_owner  out  1  requester owning oldest outstanding block
ht_owner_vld  out  1  at least one block outstanding
done_err  out  1  one-cycle pulse: ht_done while nothing outstanding
busy  out  1  a grant is active

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Requester r is active when |rq_vld[r] or rq_eob[r]. An EOB-only beat (vld=0, eob=1) is legal.
- Beat transfer on engine side: (|sc_is_vld or sc_is_eob) and is_sc_rd.
- FSM states: IDLE, GNT0, GNT1.
  - IDLE: if outstanding < MAX_OUTSTANDING and any requester is active, grant one. Round-robin: when both are active, grant the requester not granted last. last_gnt resets to 1, so requester 0 wins the first tie. The grant takes effect the next cycle: IDLE -> GNTr.
  - GNTr: sc_* = rq_*[r] combinationally; rq_rd[r] = is_sc_rd; rq_rd of the other requester = 0.
  - GNTr: on a transferred beat with eob=1 -> IDLE, last_gnt <= r, owner r pushed into the tag FIFO.
- IDLE outputs: sc_is_vld=0, sc_is_eob=0, sc_is_sym/cnt/seq_id=0, rq_rd=0.
- Inter-block gap: minimum 1 idle cycle between blocks. Grant is never revoked mid-block, regardless of the other requester or outstanding count.
- Outstanding counter (width clog2(MAX_OUTSTANDING+1)):
  - +1 on EOB transfer; -1 on ht_done when nonzero; both in the same cycle -> unchanged.
  - Never exceeds MAX_OUTSTANDING, because no grant is issued at the limit.
- Tag FIFO:
  - Depth MAX_OUTSTANDING, 1-bit entries; pushed on EOB transfer, popped on ht_done.
  - Head drives ht_owner; ht_owner_vld = (outstanding != 0). ht_owner = 0 when empty.
  - Simultaneous push and pop with count 1: head updates to the pushed entry next cycle.
- done_err: ht_done with outstanding == 0 -> done_err=1 for that cycle; counter and FIFO are unchanged.
- busy = state != IDLE.
- Reset values: state IDLE, last_gnt=1, outstanding=0, FIFO empty, all outputs 0.
- Reset mid-block: the block is abandoned; the engine side is reset together with this block.
- Latency: request to first engine beat = 1 cycle. Datapath is combinational pass-through while granted (no added beat latency).

Optional Feature:
- Macro: CR_HUF_COMP_IS_ARB_STRICT_PRIO_EN.
- Defined: in IDLE, requester 0 always wins when both are active; last_gnt is ignored, so requester 1 may starve.
- Undefined: round-robin as above.

Test Plan:
1. Single block from rq0: 3 beats, vld=4'hF, eob on beat 3, is_sc_rd=1.
   -> sc_* mirrors rq0 from the cycle after the request; IDLE after beat 3; ht_owner=0, ht_owner_vld=1.
2. Both requesters active continuously, ht_done pulsed after each block.
   -> grants alternate 0,1,0,1; with STRICT_PRIO_EN defined -> 0,0,0.
3. MAX_OUTSTANDING=2, four blocks queued, no ht_done.
   -> exactly 2 blocks pass; busy stays 0 while requesters are active.
   -> first ht_done: ht_owner pops in push order and a third grant follows next cycle.
4. is_sc_rd toggled 1,0,1,0 mid-block.
   -> rq_rd follows is_sc_rd; no beat lost or duplicated; the other requester sees rq_rd=0 throughout.
5. EOB transfer and ht_done in the same cycle with outstanding=1.
   -> outstanding stays 1; ht_owner becomes the new block's owner.
6. ht_done with nothing outstanding -> done_err=1 for one cycle, outstanding stays 0.
7. rst asserted mid-block -> next cycle all outputs 0, state IDLE.
